// File: rtl/dbg_step_ctrl.sv
// dbg_step_ctrl: debounced step button and clock-enable sequencer (halt/step/run/breakpoint) for the debug CPU
module dbg_step_ctrl #(
  parameter int PC_W    = 8,
  parameter int DEB_CNT = 10000000,
  parameter int RUN_DIV = 300,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             button,
  input  logic [1:0]       mode,
  input  logic             bp_en,
  input  logic [PC_W-1:0]  bp_addr,
  input  logic [PC_W-1:0]  pc,
  output logic             cpu_ce,
  output logic             halted,
  output logic             bp_hit,
  output logic [CNT_W-1:0] step_cnt
);
  localparam int DW = $clog2(DEB_CNT);
  localparam int RW = $clog2(RUN_DIV);
  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CNT - 1);
  localparam logic [RW-1:0] RUN_LAST = RW'(RUN_DIV - 1);

  typedef enum logic [1:0] {S_HALT, S_STEP, S_RUN, S_BRK} state_t;

  state_t        state;
  logic [1:0]    sync;
  logic [DW-1:0] deb_cnt;
  logic          btn_db;
  logic          step_req;
  logic [RW-1:0] div;
  logic          bp_armed;
  logic          run_mode;
  logic          tc;
  logic          bp_match;

  assign run_mode = mode[1];
  assign tc       = div == RUN_LAST;
  assign bp_match = mode == 2'b11 && bp_en && bp_armed && pc == bp_addr;

  // two-flop synchroniser for the asynchronous button
  always_ff @(posedge clk or negedge reset)
    if (!reset) sync <= 2'b00;
    else sync <= {sync[0], button};

  // accept a new button level only after DEB_CNT consecutive differing cycles; pulse on accepted press
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      deb_cnt  <= '0;
      btn_db   <= 1'b0;
      step_req <= 1'b0;
    end else begin
      step_req <= 1'b0;
      if (sync[1] == btn_db) deb_cnt <= '0;
      else if (deb_cnt == DEB_LAST) begin
        deb_cnt  <= '0;
        btn_db   <= sync[1];
        step_req <= sync[1];
      end else deb_cnt <= deb_cnt + 1'b1;
    end

  // control FSM; every output is registered so cpu_ce lines up with the state that issues it
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state    <= S_HALT;
      cpu_ce   <= 1'b0;
      halted   <= 1'b1;
      bp_hit   <= 1'b0;
      step_cnt <= '0;
      div      <= '0;
      bp_armed <= 1'b1;
    end else begin
      cpu_ce <= 1'b0;
      if (pc != bp_addr) bp_armed <= 1'b1;
      case (state)
        S_HALT:
          if (run_mode) begin
            state  <= S_RUN;
            div    <= '0;
            halted <= 1'b0;
          end else if (mode == 2'b01 && step_req) begin
            state    <= S_STEP;
            cpu_ce   <= 1'b1;
            step_cnt <= step_cnt + 1'b1;
            halted   <= 1'b0;
          end
        S_STEP: begin
          state  <= S_HALT;
          halted <= 1'b1;
        end
        S_RUN:
          if (!run_mode) begin
            state  <= S_HALT;
            halted <= 1'b1;
          end else if (!tc) div <= div + 1'b1;
          else if (bp_match) begin
            state  <= S_BRK;
            halted <= 1'b1;
            bp_hit <= 1'b1;
          end else begin
            div      <= '0;
            cpu_ce   <= 1'b1;
            step_cnt <= step_cnt + 1'b1;
          end
        S_BRK:
          if (mode != 2'b11) begin
            state  <= S_HALT;
            bp_hit <= 1'b0;
          end else if (step_req) begin
            state    <= S_RUN;
            div      <= '0;
            cpu_ce   <= 1'b1;
            step_cnt <= step_cnt + 1'b1;
            bp_armed <= 1'b0;
            halted   <= 1'b0;
            bp_hit   <= 1'b0;
          end
        default: state <= S_HALT;
      endcase
    end
endmodule

// File: tb/tb_dbg_step_ctrl.sv
// tb_dbg_step_ctrl: randomized scenario bench with arithmetic pulse-timing and counter model
module tb_dbg_step_ctrl;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       button = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       bp_en = 1'b0;
  logic [7:0] bp_addr = 8'd0;
  logic [7:0] pc = 8'd0;
  logic       pc_clr = 1'b0;
  logic       cpu_ce, halted, bp_hit;
  logic [3:0] step_cnt;
  int checks = 0;
  int errors = 0;
  int exp_cnt = 0;

  dbg_step_ctrl #(.PC_W(8), .DEB_CNT(4), .RUN_DIV(5), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .button(button), .mode(mode), .bp_en(bp_en),
    .bp_addr(bp_addr), .pc(pc), .cpu_ce(cpu_ce), .halted(halted),
    .bp_hit(bp_hit), .step_cnt(step_cnt)
  );

  always #5 clk = ~clk;

  // CPU stand-in: advances its PC once per clock enable
  always @(posedge clk) pc <= pc_clr ? 8'd0 : pc + {7'd0, cpu_ce};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    int first;
    reset = 1'b0; button = 1'b1; mode = 2'b10;
    repeat (3) tick();
    checks++;
    if ({cpu_ce, halted, bp_hit, step_cnt} !== 7'b0_1_0_0000) begin
      errors++; $display("FAIL reset_state got %b required %b", {cpu_ce, halted, bp_hit, step_cnt}, 7'b0_1_0_0000);
    end
    reset = 1'b1;
    first = 0;
    for (int i = 1; i <= 20 && first == 0; i++) begin
      tick();
      if (cpu_ce) first = i;
    end
    checks++;
    if (first !== 6) begin
      errors++; $display("FAIL reset_first_pulse got sample %0d required 6", first);
    end
    exp_cnt = 1;
    mode = 2'b00; button = 1'b0;
    repeat (12) tick();
    checks++;
    if (step_cnt !== exp_cnt[3:0] || halted !== 1'b1) begin
      errors++; $display("FAIL reset_after_halt got cnt %0d halted %b required cnt %0d halted 1", step_cnt, halted, exp_cnt[3:0]);
    end
  endtask

  task automatic test_bounce();
    int t, pulses, pos, hl, ll;
    mode = 2'b01; t = 0; pulses = 0; pos = 0;
    while (t < 20) begin
      hl = $urandom_range(1, 3);
      ll = $urandom_range(1, 3);
      button = 1'b1;
      repeat (hl) begin tick(); t++; pulses += int'(cpu_ce); end
      button = 1'b0;
      repeat (ll) begin tick(); t++; pulses += int'(cpu_ce); end
    end
    button = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (cpu_ce) begin pulses++; pos = i; end
    end
    checks++;
    if (pulses !== 1 || pos < 6 || pos > 10) begin
      errors++; $display("FAIL bounce_pulse got %0d pulses at %0d required 1 pulse in 6..10", pulses, pos);
    end
    exp_cnt++;
    checks++;
    if (step_cnt !== exp_cnt[3:0] || halted !== 1'b1) begin
      errors++; $display("FAIL bounce_status got cnt %0d halted %b required cnt %0d halted 1", step_cnt, halted, exp_cnt[3:0]);
    end
    button = 1'b0; pulses = 0;
    repeat (12) begin tick(); pulses += int'(cpu_ce); end
    checks++;
    if (pulses !== 0) begin
      errors++; $display("FAIL bounce_release got %0d pulses required 0", pulses);
    end
  endtask

  task automatic test_free_run(input int n);
    int last, mism;
    bit expct;
    mode = 2'b10; mism = 0;
    last = 6 + 5 * (n - 1);
    for (int i = 1; i <= last + 4; i++) begin
      tick();
      expct = i >= 6 && (i - 6) % 5 == 0;
      if (cpu_ce !== expct) mism++;
    end
    exp_cnt += n;
    checks++;
    if (mism !== 0) begin
      errors++; $display("FAIL free_run_spacing got %0d misplaced samples required 0 (n=%0d)", mism, n);
    end
    checks++;
    if (step_cnt !== exp_cnt[3:0]) begin
      errors++; $display("FAIL free_run_count got %0d required %0d", step_cnt, exp_cnt[3:0]);
    end
    mode = 2'b00;
    tick();
    checks++;
    if (cpu_ce !== 1'b0 || halted !== 1'b1) begin
      errors++; $display("FAIL free_run_stop got ce %b halted %b required ce 0 halted 1", cpu_ce, halted);
    end
  endtask

  task automatic test_breakpoint();
    int bp, pulses;
    bp = $urandom_range(3, 9);
    bp_addr = 8'(bp); bp_en = 1'b1;
    pc_clr = 1'b1; tick(); pc_clr = 1'b0;
    mode = 2'b11; pulses = 0;
    for (int i = 0; i < 200 && !bp_hit; i++) begin tick(); pulses += int'(cpu_ce); end
    exp_cnt += bp;
    checks++;
    if (bp_hit !== 1'b1 || halted !== 1'b1 || pulses !== bp || pc !== 8'(bp)) begin
      errors++; $display("FAIL bp_first got hit %b halted %b pulses %0d pc %0d required hit 1 halted 1 pulses %0d pc %0d", bp_hit, halted, pulses, pc, bp, bp);
    end
    pulses = 0;
    repeat (8) begin tick(); pulses += int'(cpu_ce); end
    checks++;
    if (pulses !== 0 || bp_hit !== 1'b1) begin
      errors++; $display("FAIL bp_hold got %0d pulses hit %b required 0 pulses hit 1", pulses, bp_hit);
    end
    button = 1'b1; pulses = 0;
    repeat (10) begin tick(); pulses += int'(cpu_ce); end
    exp_cnt++;
    checks++;
    if (pulses !== 1 || pc !== 8'(bp + 1) || bp_hit !== 1'b0 || halted !== 1'b0) begin
      errors++; $display("FAIL bp_resume got pulses %0d pc %0d hit %b halted %b required 1 %0d 0 0", pulses, pc, bp_hit, halted, bp + 1);
    end
    button = 1'b0; pulses = 0;
    for (int i = 0; i < 1400 && !bp_hit; i++) begin tick(); pulses += int'(cpu_ce); end
    exp_cnt += 255;
    checks++;
    if (bp_hit !== 1'b1 || pulses !== 255 || pc !== 8'(bp)) begin
      errors++; $display("FAIL bp_rewrap got hit %b pulses %0d pc %0d required hit 1 pulses 255 pc %0d", bp_hit, pulses, pc, bp);
    end
    checks++;
    if (step_cnt !== exp_cnt[3:0]) begin
      errors++; $display("FAIL bp_count got %0d required %0d", step_cnt, exp_cnt[3:0]);
    end
    mode = 2'b00;
    tick();
    checks++;
    if (halted !== 1'b1 || bp_hit !== 1'b0) begin
      errors++; $display("FAIL bp_exit got halted %b hit %b required 1 0", halted, bp_hit);
    end
    bp_en = 1'b0;
  endtask

  task automatic test_wrap();
    int mism;
    bit expct;
    mode = 2'b10; mism = 0;
    for (int i = 1; i <= 6 + 5 * 19; i++) begin
      tick();
      expct = i >= 6 && (i - 6) % 5 == 0;
      if (expct) exp_cnt++;
      if (cpu_ce !== expct || (expct && step_cnt !== exp_cnt[3:0])) mism++;
    end
    checks++;
    if (mism !== 0) begin
      errors++; $display("FAIL wrap_sequence got %0d bad samples required 0", mism);
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 10 && !cpu_ce; i++) tick();
    checks++;
    if (cpu_ce !== 1'b1) begin
      errors++; $display("FAIL async_wait got ce %b required 1", cpu_ce);
    end
    #2 reset = 1'b0;
    #1;
    checks++;
    if ({cpu_ce, halted, bp_hit, step_cnt} !== 7'b0_1_0_0000) begin
      errors++; $display("FAIL async_reset got %b required %b", {cpu_ce, halted, bp_hit, step_cnt}, 7'b0_1_0_0000);
    end
    exp_cnt = 0;
    mode = 2'b00;
    @(negedge clk) reset = 1'b1;
    repeat (3) tick();
    checks++;
    if (step_cnt !== exp_cnt[3:0] || halted !== 1'b1 || cpu_ce !== 1'b0) begin
      errors++; $display("FAIL async_release got cnt %0d halted %b ce %b required 0 1 0", step_cnt, halted, cpu_ce);
    end
  endtask

  initial begin
    test_reset();
    test_bounce();
    test_free_run(10);
    test_free_run($urandom_range(2, 9));
    test_breakpoint();
    test_wrap();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
